// File: rtl/lcd_bus_writer.sv
// lcd_bus_writer: pops 33-bit pixel/command words from a FIFO and drives an 8080-style LCD write bus.
// Define LCD_WRITER_SWAP_EN to send the low pixel (data[15:0]) of each pixel word first.
module lcd_bus_writer #(
  parameter int WR_LOW_CYCLES  = 2,
  parameter int WR_HIGH_CYCLES = 2
) (
  input  logic        i_clock,
  input  logic        i_nReset,
  input  logic [32:0] i_fifoData,
  input  logic        i_fifoEmpty,
  output logic        o_fifoRead,
  output logic [15:0] o_lcdData,
  output logic        o_lcdDc,
  output logic        o_lcdWrN,
  output logic        o_lcdCsN,
  output logic        o_busy
);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, WR_LOW, WR_HIGH} state_e;

  localparam logic [3:0] LOW_LOAD  = 4'(WR_LOW_CYCLES - 1);
  localparam logic [3:0] HIGH_LOAD = 4'(WR_HIGH_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  timer_q, timer_d;
  logic [1:0]  remain_q, remain_d;
  logic [15:0] pend_q, pend_d;
  logic        fifo_read_q, fifo_read_d;
  logic [15:0] lcd_data_q, lcd_data_d;
  logic        lcd_dc_q, lcd_dc_d;
  logic        lcd_wr_n_q, lcd_wr_n_d;
  logic        lcd_cs_n_q, lcd_cs_n_d;
  logic [15:0] first_half, second_half;

`ifdef LCD_WRITER_SWAP_EN
  assign first_half  = i_fifoData[15:0];
  assign second_half = i_fifoData[31:16];
`else
  assign first_half  = i_fifoData[31:16];
  assign second_half = i_fifoData[15:0];
`endif

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    remain_d    = remain_q;
    pend_d      = pend_q;
    fifo_read_d = 1'b0;
    lcd_data_d  = lcd_data_q;
    lcd_dc_d    = lcd_dc_q;
    lcd_wr_n_d  = lcd_wr_n_q;
    lcd_cs_n_d  = lcd_cs_n_q;
    case (state_q)
      IDLE: begin
        lcd_cs_n_d = 1'b1;
        lcd_wr_n_d = 1'b1;
        if (!i_fifoEmpty) begin
          fifo_read_d = 1'b1;
          lcd_cs_n_d  = 1'b0;
          state_d     = FETCH;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        // Only the second half needs keeping; the first goes straight onto the bus.
        pend_d = second_half;
        if (i_fifoData[32]) begin
          lcd_data_d = {8'h00, i_fifoData[7:0]};
          lcd_dc_d   = 1'b0;
          remain_d   = 2'd1;
        end else begin
          lcd_data_d = first_half;
          lcd_dc_d   = 1'b1;
          remain_d   = 2'd2;
        end
        lcd_wr_n_d = 1'b0;
        timer_d    = LOW_LOAD;
        state_d    = WR_LOW;
      end
      WR_LOW: begin
        if (timer_q == 4'd0) begin
          lcd_wr_n_d = 1'b1;
          timer_d    = HIGH_LOAD;
          state_d    = WR_HIGH;
        end else begin
          timer_d = timer_q - 4'd1;
        end
      end
      WR_HIGH: begin
        if (timer_q == 4'd0) begin
          remain_d = remain_q - 2'd1;
          if (remain_q != 2'd1) begin
            lcd_data_d = pend_q;
            lcd_wr_n_d = 1'b0;
            timer_d    = LOW_LOAD;
            state_d    = WR_LOW;
          end else if (!i_fifoEmpty) begin
            // Chain straight into the next word with CSn held low.
            fifo_read_d = 1'b1;
            state_d     = FETCH;
          end else begin
            lcd_cs_n_d = 1'b1;
            state_d    = IDLE;
          end
        end else begin
          timer_d = timer_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_nReset) begin
    if (!i_nReset) begin
      state_q     <= IDLE;
      timer_q     <= 4'd0;
      remain_q    <= 2'd0;
      fifo_read_q <= 1'b0;
      lcd_data_q  <= 16'h0000;
      lcd_dc_q    <= 1'b1;
      lcd_wr_n_q  <= 1'b1;
      lcd_cs_n_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      remain_q    <= remain_d;
      fifo_read_q <= fifo_read_d;
      lcd_data_q  <= lcd_data_d;
      lcd_dc_q    <= lcd_dc_d;
      lcd_wr_n_q  <= lcd_wr_n_d;
      lcd_cs_n_q  <= lcd_cs_n_d;
    end
  end

  always_ff @(posedge i_clock) begin
    pend_q <= pend_d;
  end

  assign o_fifoRead = fifo_read_q;
  assign o_lcdData  = lcd_data_q;
  assign o_lcdDc    = lcd_dc_q;
  assign o_lcdWrN   = lcd_wr_n_q;
  assign o_lcdCsN   = lcd_cs_n_q;
  assign o_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Bench for lcd_bus_writer: FIFO model feeding the DUT, timeline-based bus model checked every cycle.
`timescale 1ns/1ps
module tb_lcd_bus_writer #(
  parameter int L = 2,
  parameter int H = 2
);
  localparam int P = L + H;
`ifdef LCD_WRITER_SWAP_EN
  localparam bit SWAP = 1'b1;
`else
  localparam bit SWAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [32:0] fifo_data = '0;
  logic        fifo_empty;
  logic        fifo_read;
  logic [15:0] lcd_data;
  logic        lcd_dc, lcd_wr_n, lcd_cs_n, busy;

  lcd_bus_writer #(.WR_LOW_CYCLES(L), .WR_HIGH_CYCLES(H)) dut (
    .i_clock    (clk),
    .i_nReset   (rst_n),
    .i_fifoData (fifo_data),
    .i_fifoEmpty(fifo_empty),
    .o_fifoRead (fifo_read),
    .o_lcdData  (lcd_data),
    .o_lcdDc    (lcd_dc),
    .o_lcdWrN   (lcd_wr_n),
    .o_lcdCsN   (lcd_cs_n),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  // FIFO with registered read data, one word per pop.
  logic [32:0] mem [0:1023];
  int wptr = 0;
  int rptr = 0;
  assign fifo_empty = (wptr == rptr);
  always @(posedge clk) begin
    if (fifo_read && (wptr != rptr)) begin
      fifo_data <= mem[rptr];
      rptr      <= rptr + 1;
    end
  end

  int tests = 0, fails = 0, cyc = 0;
  int pop_cnt = 0, cs_low_cnt = 0, cs_rise_cnt = 0;
  logic [32:0] sb_q[$];
  logic [16:0] cap_q[$];
  bit   active = 0, exp_pop = 0, fresh = 1;
  int   t0 = 0, n = 0;
  logic [15:0] hw [0:1];
  logic exp_dc;
  logic prev_wr_n = 1'b1, prev_cs = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [32:0] w);
    mem[wptr] = w;
    sb_q.push_back(w);
    wptr = wptr + 1;
  endtask

  function automatic logic [32:0] rand_word();
    logic [32:0] w;
    w[31:0] = $urandom();
    w[32]   = ($urandom_range(2) == 0);
    return w;
  endfunction

  // Model: a word popped at cycle t0 writes its k-th half during cycles
  // t0+2+k*P .. t0+1+(k+1)*P, WRn low for the first L of those.
  always @(negedge clk) begin
    int rel;
    logic [32:0] w;
    cyc++;
    rel = 0;
    if (!rst_n) begin
      chk("rst_read", fifo_read, 0);
      chk("rst_data", lcd_data, 0);
      chk("rst_dc", lcd_dc, 1);
      chk("rst_wrn", lcd_wr_n, 1);
      chk("rst_csn", lcd_cs_n, 1);
      chk("rst_busy", busy, 0);
      active  = 0;
      exp_pop = 0;
      fresh   = 1;
    end else begin
      chk("pop", fifo_read, exp_pop);
      if (fifo_read) pop_cnt++;
      if (exp_pop && sb_q.size() != 0) begin
        w      = sb_q.pop_front();
        active = 1;
        fresh  = 0;
        t0     = cyc;
        if (w[32]) begin
          n = 1; exp_dc = 1'b0; hw[0] = {8'h00, w[7:0]}; hw[1] = 16'h0;
        end else begin
          n = 2; exp_dc = 1'b1;
          hw[0] = SWAP ? w[15:0] : w[31:16];
          hw[1] = SWAP ? w[31:16] : w[15:0];
        end
      end else if (active && (cyc - t0) == 2 + n * P) begin
        active = 0;
      end
      rel = cyc - t0;
      if (active) begin
        chk("csn", lcd_cs_n, 0);
        chk("busy", busy, 1);
        if (rel < 2) begin
          chk("wrn", lcd_wr_n, 1);
        end else begin
          chk("wrn", lcd_wr_n, (((rel - 2) % P) >= L) ? 1 : 0);
          chk("data", lcd_data, hw[(rel - 2) / P]);
          chk("dc", lcd_dc, exp_dc);
        end
      end else begin
        chk("csn", lcd_cs_n, 1);
        chk("wrn", lcd_wr_n, 1);
        chk("busy", busy, 0);
        if (fresh) begin
          chk("idle_data", lcd_data, 0);
          chk("idle_dc", lcd_dc, 1);
        end
      end
      exp_pop = (!active || rel == 1 + n * P) && !fifo_empty;
      if (prev_wr_n == 1'b0 && lcd_wr_n == 1'b1) cap_q.push_back({lcd_dc, lcd_data});
    end
    if (!lcd_cs_n) cs_low_cnt++;
    if (prev_cs == 1'b0 && lcd_cs_n == 1'b1) cs_rise_cnt++;
    prev_wr_n = lcd_wr_n;
    prev_cs   = lcd_cs_n;
  end

  task automatic wait_idle(input int budget);
    int k = 0;
    do begin
      tick();
      k++;
    end while ((active || exp_pop || !fifo_empty) && k < budget);
    chk("drain_timeout", {31'd0, (active || exp_pop || !fifo_empty)}, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, c0, r0;
    logic [16:0] exp3 [0:4];
    bit seen_low;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;

    // Empty FIFO: nothing moves.
    repeat (20) tick();
    chk("empty_read", fifo_read, 0);
    chk("empty_csn", lcd_cs_n, 1);
    chk("empty_data", lcd_data, 0);
    chk("empty_busy", busy, 0);

    // Single pixel word.
    cap_q.delete(); p0 = pop_cnt; c0 = cs_low_cnt;
    push(33'h0_F800_07E0);
    wait_idle(200);
    chk("px_caps", cap_q.size(), 2);
    if (cap_q.size() == 2) begin
      chk("px_w0", cap_q[0], SWAP ? {1'b1, 16'h07E0} : {1'b1, 16'hF800});
      chk("px_w1", cap_q[1], SWAP ? {1'b1, 16'hF800} : {1'b1, 16'h07E0});
    end
    chk("px_pops", pop_cnt - p0, 1);
    chk("px_cs_low", cs_low_cnt - c0, 2 + 2 * P);

    // Command word.
    cap_q.delete(); p0 = pop_cnt; c0 = cs_low_cnt;
    push(33'h1_0000_002C);
    wait_idle(200);
    chk("cmd_caps", cap_q.size(), 1);
    if (cap_q.size() == 1) chk("cmd_w0", cap_q[0], {1'b0, 16'h002C});
    chk("cmd_pops", pop_cnt - p0, 1);
    chk("cmd_cs_low", cs_low_cnt - c0, 2 + P);

    // Three queued words, back to back; command carries junk upper bits.
    cap_q.delete(); p0 = pop_cnt; c0 = cs_low_cnt; r0 = cs_rise_cnt;
    push(33'h1_5A5A_5A2A);
    push(33'h0_1234_5678);
    push(33'h0_ABCD_EF01);
    wait_idle(400);
    exp3[0] = {1'b0, 16'h002A};
    exp3[1] = SWAP ? {1'b1, 16'h5678} : {1'b1, 16'h1234};
    exp3[2] = SWAP ? {1'b1, 16'h1234} : {1'b1, 16'h5678};
    exp3[3] = SWAP ? {1'b1, 16'hEF01} : {1'b1, 16'hABCD};
    exp3[4] = SWAP ? {1'b1, 16'hABCD} : {1'b1, 16'hEF01};
    chk("seq_caps", cap_q.size(), 5);
    for (int i = 0; i < 5 && i < cap_q.size(); i++) chk("seq_w", cap_q[i], exp3[i]);
    chk("seq_pops", pop_cnt - p0, 3);
    chk("seq_cs_rise", cs_rise_cnt - r0, 1);
    chk("seq_cs_low", cs_low_cnt - c0, 3 * 2 + 5 * P);

    // Reset in the middle of a WRn-low phase.
    push(33'h0_1234_5678);
    seen_low = 0;
    for (int i = 0; i < 50 && !seen_low; i++) begin
      tick();
      if (lcd_wr_n == 1'b0) seen_low = 1;
    end
    chk("rst_wr_low_seen", {31'd0, seen_low}, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_now_wrn", lcd_wr_n, 1);
    chk("rst_now_csn", lcd_cs_n, 1);
    chk("rst_now_busy", busy, 0);
    p0 = pop_cnt;
    push(33'h0_AAAA_5555);
    repeat (5) tick();
    chk("rst_no_pop", pop_cnt - p0, 0);
    cap_q.delete();
    rst_n = 1'b1;
    wait_idle(200);
    chk("post_rst_caps", cap_q.size(), 2);
    if (cap_q.size() == 2) begin
      chk("post_rst_w0", cap_q[0], SWAP ? {1'b1, 16'h5555} : {1'b1, 16'hAAAA});
      chk("post_rst_w1", cap_q[1], SWAP ? {1'b1, 16'hAAAA} : {1'b1, 16'h5555});
    end

    // Random traffic: dense (queue builds up) then sparse (idle gaps).
    for (int i = 0; i < 400; i++) begin
      tick();
      if ($urandom_range(3) == 0) push(rand_word());
    end
    wait_idle(8000);
    for (int i = 0; i < 600; i++) begin
      tick();
      if ($urandom_range(15) == 0) push(rand_word());
    end
    wait_idle(2000);
    chk("total_pops", pop_cnt, wptr);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
